// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM channel link (transmit mux and receive deframer).
// Channel count, index width and the frame-start index live here.
package tdm_pkg;

  localparam int TDM_NUM_CH = 8;
  localparam int TDM_SEL_W  = 3;

  typedef logic [TDM_SEL_W-1:0] tdm_idx_t;

  localparam tdm_idx_t CH_FIRST = 3'd0;

endpackage

// File: rtl/tdm_frame_counter.sv
// Modulo-NUM_CH frame counter with enable and synchronous frame restart.
// Exposes the effective channel index k for this cycle and a first-channel flag.
module tdm_frame_counter
  import tdm_pkg::*;
#(
  parameter int NUM_CH = TDM_NUM_CH,
  parameter int SEL_W  = TDM_SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  output logic [SEL_W-1:0] k,
  output logic             first
);

  logic [SEL_W-1:0] cnt_r;
  logic [SEL_W-1:0] cnt_s;
  logic [SEL_W-1:0] k_s;

  // Effective index: SYNC forces channel 0 for this cycle.
  always_comb begin
    k_s = cnt_r;
    if (sync) begin
      k_s = SEL_W'(CH_FIRST);
    end else begin
      k_s = cnt_r;
    end
  end

  // Next count: advance on enable, wrap after the last channel.
  always_comb begin
    cnt_s = cnt_r;
    if (en) begin
      if (k_s == SEL_W'(NUM_CH - 1)) begin
        cnt_s = SEL_W'(CH_FIRST);
      end else begin
        cnt_s = k_s + SEL_W'(1);
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= SEL_W'(CH_FIRST);
    end else begin
      cnt_r <= cnt_s;
    end
  end

  assign k     = k_s;
  assign first = (k_s == SEL_W'(CH_FIRST));

endmodule

// File: rtl/tdm_mux_8_to_1.sv
// Transmit side of the TDM link: snapshots NUM_CH parallel bits once per frame
// and serialises them onto Y with channel index S and frame-start marker FS.
module tdm_mux_8_to_1
  import tdm_pkg::*;
#(
  parameter int NUM_CH = TDM_NUM_CH,
  parameter int SEL_W  = TDM_SEL_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              SYNC,
  input  logic [NUM_CH-1:0] D,
  output logic              Y,
  output logic [SEL_W-1:0]  S,
  output logic              FS,
  output logic              VALID
);

  logic [SEL_W-1:0]  k_s;
  logic              first_s;
  logic [NUM_CH-1:0] snap_r, snap_s;
  logic              y_r, y_s;
  logic [SEL_W-1:0]  s_r, s_s;
  logic              fs_r, fs_s;
  logic              valid_r, valid_s;

  tdm_frame_counter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_frame_counter (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (EN),
    .sync  (SYNC),
    .k     (k_s),
    .first (first_s)
  );

  // Output selection; channel 0 takes D live so it matches the fresh snapshot.
  always_comb begin
    snap_s  = snap_r;
    y_s     = y_r;
    s_s     = s_r;
    fs_s    = 1'b0;
    valid_s = 1'b0;
    if (EN) begin
      valid_s = 1'b1;
      s_s     = k_s;
      if (first_s) begin
        snap_s = D;
        y_s    = D[0];
        fs_s   = 1'b1;
      end else begin
        y_s    = snap_r[k_s];
        fs_s   = 1'b0;
      end
    end else begin
      snap_s  = snap_r;
      y_s     = y_r;
      s_s     = s_r;
    end
  end

  // Snapshot and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      snap_r  <= {NUM_CH{1'b0}};
      y_r     <= 1'b0;
      s_r     <= {SEL_W{1'b0}};
      fs_r    <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      snap_r  <= snap_s;
      y_r     <= y_s;
      s_r     <= s_s;
      fs_r    <= fs_s;
      valid_r <= valid_s;
    end
  end

  assign Y     = y_r;
  assign S     = s_r;
  assign FS    = fs_r;
  assign VALID = valid_r;

endmodule

// File: tb/tb_tdm_mux_8_to_1.sv
// Directed bench for tdm_mux_8_to_1: framing, snapshot coherence, enable
// gating, SYNC restart, asynchronous reset and multi-frame wrap.
module tb_tdm_mux_8_to_1;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       SYNC;
  logic [7:0] D;
  logic       Y;
  logic [2:0] S;
  logic       FS;
  logic       VALID;

  int n_cmp;
  int n_bad;

  tdm_mux_8_to_1 dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (EN),
    .SYNC  (SYNC),
    .D     (D),
    .Y     (Y),
    .S     (S),
    .FS    (FS),
    .VALID (VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One clock: drive inputs, wait for the edge, sample #1 later, compare {Y,S,FS,VALID}.
  task automatic cyc(input string name, input logic en_v, input logic sync_v,
                     input logic [7:0] d_v, input logic y_e, input logic [2:0] s_e,
                     input logic fs_e, input logic v_e);
    logic [5:0] got;
    logic [5:0] exp;
    EN   = en_v;
    SYNC = sync_v;
    D    = d_v;
    @(posedge CLK);
    #1;
    got = {Y, S, FS, VALID};
    exp = {y_e, s_e, fs_e, v_e};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got Y=%b S=%0d FS=%b VALID=%b, want Y=%b S=%0d FS=%b VALID=%b",
               name, got[5], got[4:2], got[1], got[0], exp[5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; EN = 1'b1; SYNC = 1'b0; D = 8'hFF;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({Y, S, FS, VALID} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 000000", {Y, S, FS, VALID});
    end
    EN = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] d_v;
    d_v = 8'b1010_0110;
    for (int i = 0; i < 8; i++)
      cyc("basic", 1'b1, 1'b0, d_v, d_v[i], 3'(i), (i == 0), 1'b1);
  endtask

  task automatic test_snapshot();
    cyc("snap_ch0", 1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b1, 1'b1);
    for (int i = 1; i < 8; i++)
      cyc("snap_hold", 1'b1, 1'b0, 8'h00, 1'b1, 3'(i), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      cyc("snap_next", 1'b1, 1'b0, 8'h00, 1'b0, 3'(i), (i == 0), 1'b1);
  endtask

  task automatic test_enable();
    cyc("en_on0",  1'b1, 1'b0, 8'h5A, 1'b0, 3'd0, 1'b1, 1'b1);
    cyc("en_off0", 1'b0, 1'b0, 8'h5A, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc("en_on1",  1'b1, 1'b0, 8'h5A, 1'b1, 3'd1, 1'b0, 1'b1);
    cyc("en_off1", 1'b0, 1'b0, 8'h5A, 1'b1, 3'd1, 1'b0, 1'b0);
    // SYNC without EN must not restart the frame.
    cyc("sync_no_en", 1'b0, 1'b1, 8'h5A, 1'b1, 3'd1, 1'b0, 1'b0);
    cyc("en_on2",  1'b1, 1'b0, 8'h5A, 1'b0, 3'd2, 1'b0, 1'b1);
  endtask

  task automatic test_sync();
    logic [7:0] d_v;
    d_v = 8'h5A;
    cyc("sync_align", 1'b1, 1'b1, d_v, d_v[0], 3'd0, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++)
      cyc("sync_pre", 1'b1, 1'b0, d_v, d_v[i], 3'(i), 1'b0, 1'b1);
    cyc("sync_restart", 1'b1, 1'b1, 8'h81, 1'b1, 3'd0, 1'b1, 1'b1);
    for (int i = 1; i < 8; i++)
      cyc("sync_post", 1'b1, 1'b0, 8'h00, (i == 7), 3'(i), 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    logic [7:0] d_v;
    d_v = 8'hE7;
    for (int i = 0; i < 6; i++)
      cyc("rst_pre", 1'b1, 1'b0, d_v, d_v[i], 3'(i), (i == 0), 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({Y, S, FS, VALID} !== 6'b0) begin
      n_bad++;
      $display("FAIL async_reset: got %b want 000000", {Y, S, FS, VALID});
    end
    EN = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    cyc("rst_idle", 1'b0, 1'b0, d_v, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc("rst_first", 1'b1, 1'b0, d_v, d_v[0], 3'd0, 1'b1, 1'b1);
    cyc("rst_second", 1'b1, 1'b0, d_v, d_v[1], 3'd1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d_v;
    d_v = 8'h3C;
    // Re-align to a frame start before the three-frame run.
    cyc("b2b_align", 1'b1, 1'b1, d_v, d_v[0], 3'd0, 1'b1, 1'b1);
    for (int i = 1; i < 8; i++)
      cyc("b2b_align", 1'b1, 1'b0, d_v, d_v[i], 3'(i), 1'b0, 1'b1);
    for (int i = 0; i < 24; i++)
      cyc("b2b_frames", 1'b1, 1'b0, d_v, d_v[i % 8], 3'(i % 8), ((i % 8) == 0), 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST_N = 1'b0; EN = 1'b0; SYNC = 1'b0; D = 8'h00;
    test_reset();
    test_basic();
    test_snapshot();
    test_enable();
    test_sync();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
